// File: rtl/huffman_pkg.sv
// Shared Huffman decoder definitions: codeword table and default sizes.
// Patterns are left-aligned in CODE_W bits (first transmitted bit in the MSB).
package huffman_pkg;

  localparam int MAX_CODE_DEF = 9;
  localparam int BUF_W_DEF    = 16;
  localparam int CODE_W       = 9;
  localparam int NUM_CODES    = 16;

  typedef struct packed {
    logic [CODE_W-1:0] pattern;
    logic [3:0]        len;
    logic signed [3:0] sym;
  } code_t;

  function automatic code_t mk(input logic [CODE_W-1:0] p, input int l, input int s);
    code_t c;
    c.pattern = p;
    c.len     = 4'(l);
    c.sym     = 4'(s);
    return c;
  endfunction

  function automatic code_t code_entry(input int idx);
    code_t c;
    case (idx)
      0:       c = mk(9'b0_0000_0000, 1,  0);
      1:       c = mk(9'b100_000000,  3,  1);
      2:       c = mk(9'b1100_00000,  4,  2);
      3:       c = mk(9'b1010_00000,  4, -3);
      4:       c = mk(9'b1101_00000,  4, -2);
      5:       c = mk(9'b1110_00000,  4, -1);
      6:       c = mk(9'b11110_0000,  5,  3);
      7:       c = mk(9'b10111_0000,  5, -4);
      8:       c = mk(9'b101101_000,  6, -5);
      9:       c = mk(9'b111111_000,  6,  4);
      10:      c = mk(9'b1011000_00,  7, -6);
      11:      c = mk(9'b1011001_00,  7,  6);
      12:      c = mk(9'b1111101_00,  7,  5);
      13:      c = mk(9'b11111000_0,  8, -7);
      14:      c = mk(9'b111110010,   9, -8);
      default: c = mk(9'b111110011,   9,  7);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational codeword match at the buffer head; a hit requires the
// whole codeword to be buffered, so partial codewords never match.
module huffman_code_lut
  import huffman_pkg::*;
#(
  parameter int MAX_CODE = MAX_CODE_DEF,
  parameter int CNT_W    = 5
) (
  input  logic [MAX_CODE-1:0] peek,
  input  logic [CNT_W-1:0]    count,
  output logic                hit,
  output logic [3:0]          length,
  output logic signed [3:0]   symbol
);

  logic [NUM_CODES-1:0] match;
  code_t                ent;

  for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_match
    localparam code_t ENT = code_entry(gi);
    localparam logic [MAX_CODE-1:0] PAT  = MAX_CODE'(ENT.pattern) << (MAX_CODE - CODE_W);
    localparam logic [MAX_CODE-1:0] MASK = ~({MAX_CODE{1'b1}} >> ENT.len);
    assign match[gi] = ((peek & MASK) == PAT) && (CNT_W'(ENT.len) <= count);
  end

  // Table is prefix-free, so at most one entry matches.
  always_comb begin
    hit    = 1'b0;
    length = '0;
    symbol = '0;
    ent    = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (match[i]) begin
        ent    = code_entry(i);
        hit    = 1'b1;
        length = ent.len;
        symbol = ent.sym;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder_top.sv
// Streaming Huffman decoder: MSB-first bit buffer fed by 0..4-bit chunks,
// one symbol removed from the head per cycle.
module huffman_decoder_top
  import huffman_pkg::*;
#(
  parameter int MAX_CODE = MAX_CODE_DEF,
  parameter int BUF_W    = BUF_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                svalid,
  input  logic [3:0]          in_bits,
  input  logic [2:0]          in_len,
  output logic                aready,
  output logic                tvalid,
  output logic signed [3:0]   decoded_symbol
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(BUF_W - 4);

  // Buffer head is the MSB; bits at and below position count are always zero.
  logic [BUF_W-1:0]  bitbuf_reg, bitbuf_next, shifted, placed;
  logic [CNT_W-1:0]  count_reg, count_next, consumed, remaining, app_len;
  logic [3:0]        aligned;
  logic              hit;
  logic [3:0]        code_len;
  logic signed [3:0] code_sym;
  logic              tvalid_reg;
  logic signed [3:0] sym_reg;

  assign aready         = reset && (count_reg <= ACCEPT_MAX);
  assign tvalid         = tvalid_reg;
  assign decoded_symbol = sym_reg;

  huffman_code_lut #(
    .MAX_CODE (MAX_CODE),
    .CNT_W    (CNT_W)
  ) u_lut (
    .peek   (bitbuf_reg[BUF_W-1 -: MAX_CODE]),
    .count  (count_reg),
    .hit    (hit),
    .length (code_len),
    .symbol (code_sym)
  );

  always_comb begin
    consumed  = hit ? CNT_W'(code_len) : '0;
    shifted   = bitbuf_reg << consumed;
    remaining = count_reg - consumed;
    app_len   = '0;
    aligned   = '0;
    if (svalid && aready && (in_len != 3'd0) && (in_len <= 3'd4)) begin
      app_len = CNT_W'(in_len);
      aligned = in_bits << (3'd4 - in_len);
    end
    // New bits land directly behind whatever survives this cycle's removal.
    placed      = {aligned, {(BUF_W-4){1'b0}}} >> remaining;
    bitbuf_next = shifted | placed;
    count_next  = remaining + app_len;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bitbuf_reg <= '0;
      count_reg  <= '0;
      tvalid_reg <= 1'b0;
      sym_reg    <= '0;
    end else begin
      bitbuf_reg <= bitbuf_next;
      count_reg  <= count_next;
      tvalid_reg <= hit;
      if (hit) sym_reg <= code_sym;
    end
  end

endmodule

// File: tb/tb_huffman_decoder_top.sv
// Directed bench for huffman_decoder_top with an expected-symbol scoreboard.
module tb_huffman_decoder_top;

  logic              clk;
  logic              reset;
  logic              svalid;
  logic [3:0]        in_bits;
  logic [2:0]        in_len;
  logic              aready;
  logic              tvalid;
  logic signed [3:0] decoded_symbol;

  int total = 0;
  int bad   = 0;
  logic signed [3:0] sb[$];
  logic signed [3:0] last_exp = 0;

  logic [8:0] cw_bits[16];
  int         cw_len[16];

  huffman_decoder_top dut (
    .clk            (clk),
    .reset          (reset),
    .svalid         (svalid),
    .in_bits        (in_bits),
    .in_len         (in_len),
    .aready         (aready),
    .tvalid         (tvalid),
    .decoded_symbol (decoded_symbol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every strobe must match the oldest expected symbol.
  always @(negedge clk) begin
    if (reset && tvalid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL extra_output observed=%0d expected=none", decoded_symbol);
      end
      if (sb.size() > 0) begin
        logic signed [3:0] exp_sym;
        exp_sym = sb.pop_front();
        total++;
        assert (decoded_symbol === exp_sym) else begin
          bad++;
          $error("FAIL symbol observed=%0d expected=%0d", decoded_symbol, exp_sym);
        end
        $display("out symbol=%0d expected=%0d", decoded_symbol, exp_sym);
        last_exp = exp_sym;
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [3:0] b, input logic [2:0] l);
    int tries = 0;
    bit ok    = 1'b0;
    while (!ok && tries < 50) begin
      @(negedge clk);
      svalid  = 1'b1;
      in_bits = b;
      in_len  = l;
      ok      = aready;
      tries++;
      @(posedge clk);
    end
    #1 svalid = 1'b0;
    $display("send bits=%b len=%0d accepted=%0d", b, l, ok);
    check("send_accept", int'(ok), 1);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_idle"}, int'(tvalid), 0);
    check({tag, "_hold"}, int'(decoded_symbol), int'(last_exp));
  endtask

  initial begin
    int accepted;
    int low_cycles;
    bit bq[$];
    logic [3:0] v;
    int n;

    cw_bits = '{9'b111110010, 9'b11111000, 9'b1011000, 9'b101101, 9'b10111,
                9'b1010, 9'b1101, 9'b1110, 9'b0, 9'b100, 9'b1100, 9'b11110,
                9'b111111, 9'b1111101, 9'b1011001, 9'b111110011};
    cw_len  = '{9, 8, 7, 6, 5, 4, 4, 4, 1, 3, 4, 5, 6, 7, 7, 9};

    reset = 1'b0; svalid = 1'b0; in_bits = '0; in_len = '0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_tvalid", int'(tvalid), 0);
      check("rst_symbol", int'(decoded_symbol), 0);
      check("rst_aready", int'(aready), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_aready", int'(aready), 1);

    // Single chunk "100" -> 1, with first-output latency
    sb.push_back(4'sd1);
    send(4'b0100, 3'd4 - 3'd1);
    @(negedge clk);
    check("lat_edge_n1", int'(tvalid), 0);
    @(negedge clk);
    check("lat_strobe", int'(tvalid), 1);
    drain("single");

    // Split codeword 1111|1001|0 -> -8 only after the third chunk
    send(4'b1111, 3'd4);
    send(4'b1001, 3'd4);
    repeat (3) @(negedge clk);
    sb.push_back(-4'sd8);
    send(4'b0000, 3'd1);
    drain("split");

    // Every symbol, streamed as 4-bit MSB-first chunks
    for (int s = -8; s <= 7; s++) begin
      for (int k = cw_len[s+8] - 1; k >= 0; k--) bq.push_back(cw_bits[s+8][k]);
      sb.push_back(4'(s));
    end
    while (bq.size() > 0) begin
      n = (bq.size() < 4) ? bq.size() : 4;
      v = '0;
      for (int k = 0; k < n; k++) v = {v[2:0], bq.pop_front()};
      send(v, 3'(n));
    end
    drain("all_syms");

    // Reset mid-codeword discards the partial bits and clears outputs
    send(4'b1111, 3'd4);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check("midrst_symbol", int'(decoded_symbol), 0);
    check("midrst_tvalid", int'(tvalid), 0);
    last_exp = 0;
    sb.push_back(4'sd1);
    send(4'b0100, 3'd3);
    drain("mid_reset");

    // Zero-length and oversize chunks append nothing
    send(4'b1111, 3'd0);
    send(4'b1111, 3'd6);
    sb.push_back(-4'sd1);
    send(4'b1110, 3'd4);
    drain("len_edge");

    // Packing: four zeros in one chunk -> four consecutive symbol-0 outputs
    repeat (4) sb.push_back(4'sd0);
    send(4'b0000, 3'd4);
    drain("packing");

    // Backpressure: continuous offers, only accepted chunks produce output
    accepted = 0;
    low_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      svalid = 1'b1; in_bits = 4'b0000; in_len = 3'd4;
      if (aready) begin
        accepted++;
        repeat (4) sb.push_back(4'sd0);
      end else begin
        low_cycles++;
      end
      @(posedge clk);
    end
    #1 svalid = 1'b0;
    $display("backpressure accepted=%0d stalled=%0d", accepted, low_cycles);
    total++;
    assert (low_cycles > 0) else begin
      bad++;
      $error("FAIL bp_aready_drop observed=%0d expected=>0", low_cycles);
    end
    drain("backpressure");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
